// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch/jump
// redirects, and a multi-cycle mult/div hold on EXE, plus saturating perf counters.
module pipeline_hazard_sequencer #(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             id_uses_rt,
  input  logic             ID_EXE_MemRead,
  input  logic [4:0]       ID_EXE_RtReg,
  input  logic             id_jump,
  input  logic             id_md_start,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_exe_bubble,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_flush,
  output logic [1:0]       pc_sel,
  output logic             md_busy,
  output logic             md_abort,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [5:0] MD_LOAD       = 6'(MD_LATENCY - 1);

  state_t           state_q, state_d;
  logic [5:0]       md_cnt_q, md_cnt_d;
  logic             md_abort_q, md_abort_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             lu;
  logic             flush_evt;

  always_comb begin
    lu = ID_EXE_MemRead && (ID_EXE_RtReg != 5'd0) &&
         ((ID_EXE_RtReg == IF_ID_Rs) || (id_uses_rt && (ID_EXE_RtReg == IF_ID_Rt)));
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_exe_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    pc_sel        = PC_SEL_SEQ;
    flush_evt     = 1'b0;
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    md_abort_d    = 1'b0;

    if (!rst_n) begin
      // outputs held at their run defaults while reset is asserted
      state_d  = RUN;
      md_cnt_d = '0;
    end else if (branch_taken) begin
      pc_sel        = PC_SEL_BRANCH;
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      flush_evt     = 1'b1;
      if (state_q == MD_BUSY) begin
        state_d    = RUN;
        md_cnt_d   = '0;
        md_abort_d = 1'b1;
      end
    end else if (state_q == MD_BUSY) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
      // counter runs MD_LATENCY-1 down to 0, giving MD_LATENCY busy cycles
      if (md_cnt_q == 6'd0) begin
        state_d = RUN;
      end else begin
        md_cnt_d = md_cnt_q - 6'd1;
      end
    end else if (lu) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else if (id_md_start) begin
      state_d  = MD_BUSY;
      md_cnt_d = MD_LOAD;
    end else if (id_jump) begin
      pc_sel      = PC_SEL_JUMP;
      if_id_flush = 1'b1;
      flush_evt   = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    flush_d = flush_q;
    if (flush_evt && (flush_q != '1)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      md_cnt_q   <= '0;
      md_abort_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      md_abort_q <= md_abort_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign md_busy      = (state_q == MD_BUSY);
  assign md_abort     = md_abort_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed self-checking bench for pipeline_hazard_sequencer (MD_LATENCY=8, CNT_W=4).
module tb_pipeline_hazard_sequencer;

  logic       clk;
  logic       rst_n;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       id_uses_rt;
  logic       ID_EXE_MemRead;
  logic [4:0] ID_EXE_RtReg;
  logic       id_jump;
  logic       id_md_start;
  logic       branch_taken;
  logic       pc_write;
  logic       if_id_write;
  logic       id_exe_bubble;
  logic       if_id_flush;
  logic       id_exe_flush;
  logic       exe_mem_flush;
  logic [1:0] pc_sel;
  logic       md_busy;
  logic       md_abort;
  logic [3:0] stall_cycles;
  logic [3:0] flush_events;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_sequencer #(.MD_LATENCY(8), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_Rs       (IF_ID_Rs),
    .IF_ID_Rt       (IF_ID_Rt),
    .id_uses_rt     (id_uses_rt),
    .ID_EXE_MemRead (ID_EXE_MemRead),
    .ID_EXE_RtReg   (ID_EXE_RtReg),
    .id_jump        (id_jump),
    .id_md_start    (id_md_start),
    .branch_taken   (branch_taken),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_exe_bubble  (id_exe_bubble),
    .if_id_flush    (if_id_flush),
    .id_exe_flush   (id_exe_flush),
    .exe_mem_flush  (exe_mem_flush),
    .pc_sel         (pc_sel),
    .md_busy        (md_busy),
    .md_abort       (md_abort),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IF_ID_Rs       = 5'd0;
    IF_ID_Rt       = 5'd0;
    id_uses_rt     = 1'b0;
    ID_EXE_MemRead = 1'b0;
    ID_EXE_RtReg   = 5'd0;
    id_jump        = 1'b0;
    id_md_start    = 1'b0;
    branch_taken   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // hazard-looking inputs during reset must not stall
    ID_EXE_MemRead = 1'b1;
    ID_EXE_RtReg   = 5'd8;
    IF_ID_Rs       = 5'd8;
    #2;
    chk("rst_pc_write", int'(pc_write), 1);
    chk("rst_if_id_write", int'(if_id_write), 1);
    chk("rst_bubble", int'(id_exe_bubble), 0);
    chk("rst_pc_sel", int'(pc_sel), 0);
    chk("rst_md_busy", int'(md_busy), 0);
    chk("rst_md_abort", int'(md_abort), 0);
    chk("rst_stall", int'(stall_cycles), 0);
    chk("rst_flush_ev", int'(flush_events), 0);
    tick();
    tick();
    clear_inputs();
    rst_n = 1'b1;

    // load-use on rs
    tick();
    ID_EXE_MemRead = 1'b1;
    ID_EXE_RtReg   = 5'd8;
    IF_ID_Rs       = 5'd8;
    #1;
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_if_id_write", int'(if_id_write), 0);
    chk("lu_bubble", int'(id_exe_bubble), 1);
    tick();
    ID_EXE_MemRead = 1'b0;
    #1;
    chk("lu_after_pc_write", int'(pc_write), 1);
    chk("lu_after_if_id_write", int'(if_id_write), 1);
    chk("lu_after_bubble", int'(id_exe_bubble), 0);
    chk("lu_stall_cnt", int'(stall_cycles), 1);

    // no false hazards
    ID_EXE_MemRead = 1'b1;
    ID_EXE_RtReg   = 5'd0;
    IF_ID_Rs       = 5'd0;
    #1;
    chk("nohaz_r0", int'(pc_write), 1);
    ID_EXE_RtReg = 5'd9;
    IF_ID_Rt     = 5'd9;
    IF_ID_Rs     = 5'd3;
    id_uses_rt   = 1'b0;
    #1;
    chk("nohaz_rt_unused", int'(pc_write), 1);
    id_uses_rt = 1'b1;
    #1;
    chk("haz_rt_used", int'(pc_write), 0);
    clear_inputs();

    // mult/div full hold
    tick();
    id_md_start = 1'b1;
    #1;
    chk("md_issue_pc_write", int'(pc_write), 1);
    chk("md_issue_busy", int'(md_busy), 0);
    tick();
    id_md_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("md_busy_c%0d", i), int'(md_busy), 1);
      chk($sformatf("md_pcw_c%0d", i), int'(pc_write), 0);
      chk($sformatf("md_bubble_c%0d", i), int'(id_exe_bubble), 1);
      tick();
    end
    #1;
    chk("md_done_busy", int'(md_busy), 0);
    chk("md_done_pc_write", int'(pc_write), 1);
    chk("md_stall_cnt", int'(stall_cycles), 9);

    // branch aborts mult/div in its 3rd busy cycle
    id_md_start = 1'b1;
    tick();
    id_md_start = 1'b0;
    tick();
    tick();
    branch_taken = 1'b1;
    #1;
    chk("abort_pc_sel", int'(pc_sel), 1);
    chk("abort_pc_write", int'(pc_write), 1);
    chk("abort_if_id_flush", int'(if_id_flush), 1);
    chk("abort_id_exe_flush", int'(id_exe_flush), 1);
    chk("abort_exe_mem_flush", int'(exe_mem_flush), 1);
    chk("abort_bubble", int'(id_exe_bubble), 0);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("abort_md_busy", int'(md_busy), 0);
    chk("abort_md_abort", int'(md_abort), 1);
    chk("abort_flush_ev", int'(flush_events), 1);
    chk("abort_stall_cnt", int'(stall_cycles), 11);
    tick();
    chk("abort_pulse_end", int'(md_abort), 0);

    // branch beats load-use
    ID_EXE_MemRead = 1'b1;
    ID_EXE_RtReg   = 5'd8;
    IF_ID_Rs       = 5'd8;
    branch_taken   = 1'b1;
    #1;
    chk("br_lu_pc_write", int'(pc_write), 1);
    chk("br_lu_pc_sel", int'(pc_sel), 1);
    chk("br_lu_bubble", int'(id_exe_bubble), 0);
    chk("br_lu_id_exe_flush", int'(id_exe_flush), 1);
    tick();
    clear_inputs();

    // jump in RUN
    id_jump = 1'b1;
    #1;
    chk("jmp_pc_sel", int'(pc_sel), 2);
    chk("jmp_if_id_flush", int'(if_id_flush), 1);
    chk("jmp_id_exe_flush", int'(id_exe_flush), 0);
    chk("jmp_exe_mem_flush", int'(exe_mem_flush), 0);
    chk("jmp_pc_write", int'(pc_write), 1);
    tick();
    id_jump = 1'b0;
    #1;
    chk("jmp_flush_ev", int'(flush_events), 3);
    chk("jmp_stall_cnt", int'(stall_cycles), 11);

    // load-use defers mult/div issue by one cycle
    ID_EXE_MemRead = 1'b1;
    ID_EXE_RtReg   = 5'd8;
    IF_ID_Rs       = 5'd8;
    id_md_start    = 1'b1;
    #1;
    chk("lu_md_pc_write", int'(pc_write), 0);
    tick();
    ID_EXE_MemRead = 1'b0;
    #1;
    chk("lu_md_issue_pcw", int'(pc_write), 1);
    chk("lu_md_issue_busy", int'(md_busy), 0);
    tick();
    clear_inputs();
    #1;
    chk("lu_md_busy", int'(md_busy), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    // 12 stalls before this hold plus 8 more saturates a 4-bit counter
    chk("sat_stall_cnt", int'(stall_cycles), 15);
    chk("sat_md_busy", int'(md_busy), 0);

    // reset in the middle of MD_BUSY
    id_md_start = 1'b1;
    tick();
    id_md_start = 1'b0;
    tick();
    chk("mid_md_busy", int'(md_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(md_busy), 0);
    chk("rst_mid_pc_write", int'(pc_write), 1);
    chk("rst_mid_stall", int'(stall_cycles), 0);
    chk("rst_mid_flush_ev", int'(flush_events), 0);
    tick();
    chk("rst_mid_abort", int'(md_abort), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_exit_busy", int'(md_busy), 0);
    chk("rst_exit_abort", int'(md_abort), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
